// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the PS/2 keyboard receive path.
//   - FSM state encoding for the frame deserialiser
//   - frame geometry (PS2_DATA_BITS)
//   - default FIFO depth and frame timeout
//   - odd-parity check helper
package kbd_pkg;

    localparam int PS2_DATA_BITS      = 8;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 200000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // True when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full, or when
//                full but a pop is accepted in the same cycle
//   pop        : read request; ignored while empty
//   dout       : head entry, forced to 0 while empty
//   empty/full : occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Equal low bits with differing wrap bits means the writer is a full lap ahead.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    // A simultaneous pop frees the slot a full FIFO needs.
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; contents are only visible through valid pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Read and write pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 device-to-host frame receiver with a scan-code FIFO.
//   clk, rst        : system clock, synchronous active-high reset
//   ps2_clk/data    : raw asynchronous PS/2 pins
//   kbd_read_enable : pop request, one byte per high cycle
//   kbd_data        : FIFO head byte (0 when empty)
//   kbd_ready       : FIFO not empty
//   kbd_overflow    : sticky, a received byte was dropped on a full FIFO
//   frame_err       : one-cycle pulse when a frame is discarded
module ps2_kbd_rx
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       kbd_read_enable,
    output logic [7:0] kbd_data,
    output logic       kbd_ready,
    output logic       kbd_overflow,
    output logic       frame_err
);

    localparam int TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BW        = $clog2(PS2_DATA_BITS) + 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(PS2_DATA_BITS - 1);

    logic ps2_clk_meta_r, ps2_clk_sync_r, ps2_clk_prev_r;
    logic ps2_data_meta_r, ps2_data_sync_r;
    logic fall_s;

    ps2_state_e               state_r;
    logic [PS2_DATA_BITS-1:0] shift_r;
    logic [BW-1:0]            bit_cnt_r;
    logic [TW-1:0]            timer_r;
    logic                     parity_r;
    logic                     frame_err_r;
    logic                     overflow_r;

    logic       push_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic [7:0] fifo_dout_s;

    // Two-flop synchronisers plus a history flop for edge detection; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_meta_r  <= 1'b1;
            ps2_clk_sync_r  <= 1'b1;
            ps2_clk_prev_r  <= 1'b1;
            ps2_data_meta_r <= 1'b1;
            ps2_data_sync_r <= 1'b1;
        end else begin
            ps2_clk_meta_r  <= ps2_clk;
            ps2_clk_sync_r  <= ps2_clk_meta_r;
            ps2_clk_prev_r  <= ps2_clk_sync_r;
            ps2_data_meta_r <= ps2_data;
            ps2_data_sync_r <= ps2_data_meta_r;
        end
    end

    assign fall_s = ps2_clk_prev_r && !ps2_clk_sync_r;

    // Push in the stop-bit fall cycle so the byte lands on that cycle's closing edge.
    always_comb begin
        push_s = 1'b0;
        if ((state_r == STOP) && fall_s && ps2_data_sync_r &&
            odd_parity_ok(shift_r, parity_r)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Frame deserialiser FSM with inter-edge timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_r     <= {PS2_DATA_BITS{1'b0}};
            bit_cnt_r   <= {BW{1'b0}};
            timer_r     <= {TW{1'b0}};
            parity_r    <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if ((state_r != IDLE) && !fall_s) begin
                // Mid-frame with no edge: age the frame, abort when it goes stale.
                if (timer_r == TIMER_MAX) begin
                    state_r     <= IDLE;
                    timer_r     <= {TW{1'b0}};
                    frame_err_r <= 1'b1;
                end else begin
                    timer_r <= timer_r + TW'(1'b1);
                end
            end else if (fall_s) begin
                timer_r <= {TW{1'b0}};
                case (state_r)
                    IDLE: begin
                        // A high level on a fall is not a start bit; ignore it quietly.
                        if (!ps2_data_sync_r) begin
                            bit_cnt_r <= {BW{1'b0}};
                            state_r   <= DATA;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DATA: begin
                        shift_r   <= {ps2_data_sync_r, shift_r[PS2_DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + BW'(1'b1);
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r <= PARITY;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                    PARITY: begin
                        parity_r <= ps2_data_sync_r;
                        state_r  <= STOP;
                    end
                    STOP: begin
                        frame_err_r <= !push_s;
                        state_r     <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else begin
                timer_r <= {TW{1'b0}};
            end
        end
    end

    // Sticky overflow: a push lost because the FIFO was full and nothing was popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (push_s && fifo_full_s && !kbd_read_enable) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (shift_r),
        .pop   (kbd_read_enable),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    assign kbd_data     = fifo_dout_s;
    assign kbd_ready    = !fifo_empty_s;
    assign kbd_overflow = overflow_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: randomized and directed bench for ps2_kbd_rx. A byte queue
// models the FIFO, a flag models overflow and a counter tracks expected frame errors.
module tb_ps2_kbd_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       kbd_read_enable = 1'b0;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic       movf = 1'b0;
    int         exp_err = 0;
    int         err_pulses = 0;
    int         err_hi = 0;
    logic       fe_prev = 1'b0;

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .kbd_read_enable (kbd_read_enable),
        .kbd_data        (kbd_data),
        .kbd_ready       (kbd_ready),
        .kbd_overflow    (kbd_overflow),
        .frame_err       (frame_err)
    );

    // frame_err monitor: counts pulses and total high cycles.
    always @(posedge clk) begin
        if (frame_err) err_hi <= err_hi + 1;
        if (frame_err && !fe_prev) err_pulses <= err_pulses + 1;
        fe_prev <= frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":ready"}, kbd_ready, mq.size() != 0);
        chk({where, ":data"}, kbd_data, (mq.size() != 0) ? mq[0] : 8'h00);
        chk({where, ":ovf"}, kbd_overflow, movf);
        chk({where, ":errcnt"}, err_pulses, exp_err);
        chk({where, ":errwidth"}, err_hi, exp_err);
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        idle(5);
        ps2_clk = 1'b0;
        idle(10);
        ps2_clk = 1'b1;
        idle(5);
    endtask

    // One 11-bit frame; optionally corrupt parity/stop, pop during the stop-fall
    // cycle, or check the push latency relative to the stop falling edge.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_stop, input bit chk_lat);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(bits[i]);
        ps2_data = bits[10];
        idle(5);
        ps2_clk = 1'b0;
        // Two flops of sync plus edge detect: the fall is seen two edges later.
        idle(2);
        if (chk_lat) chk("lat_pre", kbd_ready, mq.size() != 0);
        if (pop_stop) begin
            chk("pop_head", kbd_data, (mq.size() != 0) ? mq[0] : 8'h00);
            kbd_read_enable = 1'b1;
        end
        idle(1);
        kbd_read_enable = 1'b0;
        if (pop_stop && mq.size() != 0) void'(mq.pop_front());
        if (bad_par || bad_stop) exp_err++;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else movf = 1'b1;
        if (chk_lat) chk("lat_post", kbd_ready, mq.size() != 0);
        idle(8);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        idle(5);
        check_outputs("frame");
    endtask

    task automatic pop_one();
        chk("pop_data", kbd_data, (mq.size() != 0) ? mq[0] : 8'h00);
        kbd_read_enable = 1'b1;
        idle(1);
        kbd_read_enable = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        check_outputs("pop");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        idle(2);
        chk("rst:data", kbd_data, 8'h00);
        chk("rst:ready", kbd_ready, 1'b0);
        chk("rst:ovf", kbd_overflow, 1'b0);
        chk("rst:ferr", frame_err, 1'b0);
        rst = 1'b0;
        mq.delete();
        movf = 1'b0;
        idle(2);
    endtask

    initial begin
        idle(3);
        do_reset();

        // Valid 0x1C with push latency check.
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
        // Pop it, then pop while empty.
        pop_one();
        pop_one();
        pop_one();
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_one();

        // Bad parity is discarded; next frame still good.
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_one();
        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);

        // Nine frames without reads: last one overflows.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) pop_one();

        // Full FIFO with a pop in the same cycle as the ninth push.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop_one();
        pop_one();

        // Timeout after start plus 4 data bits.
        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
        idle(TO - 50);
        chk("to_early", err_pulses, exp_err);
        idle(100);
        exp_err++;
        check_outputs("timeout");
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_one();

        // Reset mid-frame.
        send_frame(8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        do_reset();
        check_outputs("post_rst");
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_one();

        // Randomized traffic against the model.
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                send_frame(8'($urandom_range(0, 255)),
                           $urandom_range(0, 7) == 0,
                           $urandom_range(0, 7) == 0,
                           $urandom_range(0, 3) == 0,
                           1'b0);
            end else begin
                pop_one();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
